// File: rtl/sort_pkg.sv
// Shared definitions for the sorter subsystem: default geometry, the
// collector state encoding and a counter-width helper.
package sort_pkg;

  localparam int unsigned SORT_DATA_N = 4;
  localparam int unsigned SORT_DATA_W = 4;
  localparam int unsigned CNT_W       = $clog2(SORT_DATA_N + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } coll_state_e;

  // Bits needed to count 0..n inclusive
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_order_chk.sv
// Order checker for the result stream: remembers the previous accepted word
// and keeps a sticky flag when a word is smaller than its predecessor.
//   clk, rst_n  clock, synchronous active-low reset
//   clr_i       start of a new run, clears the sticky flag
//   en_i        a word is being accepted this cycle
//   first_i     the accepted word is word 0 of its run (no comparison)
//   data_i      accepted word
//   flag_c_o    combinational: flag value including this cycle's word
module sort_order_chk
  import sort_pkg::*;
#(
  parameter int unsigned DATA_W = SORT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              first_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              flag_c_o
);

  logic [DATA_W-1:0] prev_q;
  logic              flag_q;

  // Clear takes priority over the held flag; a new word 0 never compares
  assign flag_c_o = (clr_i ? 1'b0 : flag_q) |
                    (en_i && !first_i && (data_i < prev_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_c_o;
      if (en_i) prev_q <= data_i;
    end
  end

endmodule

// File: rtl/sort_result_collector.sv
// Collects the sorter's serial result words into an array, flags
// out-of-order data, inter-word timeouts and words arriving with no run open.
//   clk, rst_n   clock, synchronous active-low reset
//   arm          opens (or restarts) a collection run
//   out_vld      word strobe, data_out sampled when high
//   data_arr     collected words, index 0 = first received
//   done         pulse: run completed with DATA_N words
//   busy         run open
//   order_err    with done: some word was below its predecessor
//   timeout_err  pulse: run aborted, no word within TIMEOUT_CYC cycles
//   stray_err    pulse: word seen with no run open
//   word_cnt     words captured in the current/last run
module sort_result_collector
  import sort_pkg::*;
#(
  parameter int unsigned DATA_N      = SORT_DATA_N,
  parameter int unsigned DATA_W      = SORT_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arm,
  input  logic                           out_vld,
  input  logic [DATA_W-1:0]              data_out,
  output logic [DATA_N-1:0][DATA_W-1:0]  data_arr,
  output logic                           done,
  output logic                           busy,
  output logic                           order_err,
  output logic                           timeout_err,
  output logic                           stray_err,
  output logic [$clog2(DATA_N+1)-1:0]    word_cnt
);

  localparam int unsigned WCNT_W = cnt_width(DATA_N);
  localparam int unsigned TMR_W  = cnt_width(TIMEOUT_CYC);

  coll_state_e                    state_q;
  logic [DATA_N-1:0][DATA_W-1:0]  arr_q;
  logic [WCNT_W-1:0]              cnt_q;
  logic [TMR_W-1:0]               timer_q;
  logic                           done_q;
  logic                           order_q;
  logic                           to_q;
  logic                           stray_q;
  logic                           chk_en;
  logic                           chk_first;
  logic                           flag_c;

  // Words are only accepted while a run is already open
  assign chk_en    = out_vld && (state_q == COLLECT);
  assign chk_first = arm || (cnt_q == WCNT_W'(0));

  sort_order_chk #(
    .DATA_W (DATA_W)
  ) u_order_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (arm),
    .en_i     (chk_en),
    .first_i  (chk_first),
    .data_i   (data_out),
    .flag_c_o (flag_c)
  );

  // Collection FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      arr_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      order_q <= 1'b0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            timer_q <= '0;
            order_q <= 1'b0;
          end else if (out_vld) begin
            stray_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (arm) begin
            // Restart; a coincident word becomes word 0 of the new run
            timer_q <= '0;
            order_q <= 1'b0;
            cnt_q   <= out_vld ? WCNT_W'(1) : WCNT_W'(0);
            if (out_vld) arr_q[0] <= data_out;
          end else if (out_vld) begin
            for (int unsigned i = 0; i < DATA_N; i++) begin
              if (cnt_q == WCNT_W'(i)) arr_q[i] <= data_out;
            end
            cnt_q   <= cnt_q + WCNT_W'(1);
            timer_q <= '0;
            if (cnt_q == WCNT_W'(DATA_N - 1)) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              order_q <= flag_c;
            end
          end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            state_q <= IDLE;
            to_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_arr    = arr_q;
  assign done        = done_q;
  assign busy        = (state_q == COLLECT);
  assign order_err   = order_q;
  assign timeout_err = to_q;
  assign stray_err   = stray_q;
  assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_sort_result_collector.sv
module tb_sort_result_collector;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = $clog2(N + 1);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  arm;
  logic                  out_vld;
  logic [W-1:0]          data_out;
  logic [N-1:0][W-1:0]   data_arr;
  logic                  done;
  logic                  busy;
  logic                  order_err;
  logic                  timeout_err;
  logic                  stray_err;
  logic [CW-1:0]         word_cnt;

  always #5 clk = ~clk;

  sort_result_collector #(
    .DATA_N      (N),
    .DATA_W      (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .out_vld     (out_vld),
    .data_out    (data_out),
    .data_arr    (data_arr),
    .done        (done),
    .busy        (busy),
    .order_err   (order_err),
    .timeout_err (timeout_err),
    .stray_err   (stray_err),
    .word_cnt    (word_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is a queue of received words
  bit                  m_valid = 1'b0;
  bit                  m_open;
  int                  m_idle;
  logic [N-1:0][W-1:0] m_arr;
  int                  m_cnt;
  bit                  m_done, m_order, m_to, m_stray;
  logic [W-1:0]        m_q[$];

  always @(posedge clk) begin
    bit was_open;
    m_done  = 1'b0;
    m_to    = 1'b0;
    m_stray = 1'b0;
    was_open = m_open;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_open  = 1'b0;
      m_idle  = 0;
      m_arr   = '0;
      m_cnt   = 0;
      m_order = 1'b0;
      m_q.delete();
    end else if (arm) begin
      m_open  = 1'b1;
      m_idle  = 0;
      m_order = 1'b0;
      m_q.delete();
      if (was_open && out_vld) begin
        m_q.push_back(data_out);
        m_arr[0] = data_out;
      end
      m_cnt = m_q.size();
    end else if (!m_open) begin
      if (out_vld) m_stray = 1'b1;
    end else if (out_vld) begin
      m_q.push_back(data_out);
      m_arr[m_q.size() - 1] = data_out;
      m_idle = 0;
      m_cnt  = m_q.size();
      if (m_q.size() == N) begin
        m_open = 1'b0;
        m_done = 1'b1;
        for (int i = 1; i < N; i++)
          if (m_q[i] < m_q[i-1]) m_order = 1'b1;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin
        m_open = 1'b0;
        m_to   = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",        32'(busy),        32'(m_open));
      chk("done",        32'(done),        32'(m_done));
      chk("order_err",   32'(order_err),   32'(m_order));
      chk("timeout_err", 32'(timeout_err), 32'(m_to));
      chk("stray_err",   32'(stray_err),   32'(m_stray));
      chk("word_cnt",    32'(word_cnt),    32'(m_cnt));
      chk("data_arr",    32'(data_arr),    32'(m_arr));
    end
  end

  task automatic drive(input logic a, input logic v, input logic [W-1:0] d);
    @(negedge clk);
    arm      = a;
    out_vld  = v;
    data_out = d;
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; out_vld = 1'b0; data_out = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("lit_rst_arr",  32'(data_arr), 32'h0);
    chk("lit_rst_cnt",  32'(word_cnt), 32'h0);
    chk("lit_rst_busy", 32'(busy),     32'h0);

    // Run 1: 1,3,3,9 back to back; arm again in the done cycle
    drive(1, 0, 4'h0);
    drive(0, 1, 4'h1);
    drive(0, 1, 4'h3);
    drive(0, 1, 4'h3);
    drive(0, 1, 4'h9);
    drive(1, 0, 4'h0);
    chk("lit_r1_done",  32'(done),      32'h1);
    chk("lit_r1_arr",   32'(data_arr),  32'h9331);
    chk("lit_r1_order", 32'(order_err), 32'h0);
    chk("lit_r1_cnt",   32'(word_cnt),  32'h4);
    chk("lit_r1_busy",  32'(busy),      32'h0);

    // Run 2: 5,2,7,8 with 2-cycle gaps
    drive(0, 1, 4'h5);
    chk("lit_r2_busy", 32'(busy), 32'h1);
    repeat (2) drive(0, 0, 4'h0);
    drive(0, 1, 4'h2);
    repeat (2) drive(0, 0, 4'h0);
    drive(0, 1, 4'h7);
    repeat (2) drive(0, 0, 4'h0);
    drive(0, 1, 4'h8);
    drive(0, 0, 4'h0);
    chk("lit_r2_done",  32'(done),      32'h1);
    chk("lit_r2_arr",   32'(data_arr),  32'h8725);
    chk("lit_r2_order", 32'(order_err), 32'h1);

    // Run 3: two words then silence until timeout
    drive(1, 0, 4'h0);
    drive(0, 1, 4'h4);
    chk("lit_r3_order_clr", 32'(order_err), 32'h0);
    drive(0, 1, 4'h6);
    repeat (64) drive(0, 0, 4'h0);
    chk("lit_r3_pre_busy", 32'(busy),        32'h1);
    chk("lit_r3_pre_to",   32'(timeout_err), 32'h0);
    drive(0, 0, 4'h0);
    chk("lit_r3_to",   32'(timeout_err), 32'h1);
    chk("lit_r3_busy", 32'(busy),        32'h0);
    chk("lit_r3_cnt",  32'(word_cnt),    32'h2);
    chk("lit_r3_done", 32'(done),        32'h0);
    drive(0, 0, 4'h0);
    chk("lit_r3_to_pulse", 32'(timeout_err), 32'h0);

    // Stray word in IDLE
    drive(0, 1, 4'hA);
    drive(0, 0, 4'h0);
    chk("lit_stray",     32'(stray_err), 32'h1);
    chk("lit_stray_arr", 32'(data_arr),  32'h8764);

    // Reset in the middle of a run
    drive(1, 0, 4'h0);
    drive(0, 1, 4'h1);
    drive(0, 1, 4'h2);
    drive(0, 0, 4'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("lit_mrst_arr",  32'(data_arr), 32'h0);
    chk("lit_mrst_cnt",  32'(word_cnt), 32'h0);
    chk("lit_mrst_busy", 32'(busy),     32'h0);
    out_vld = 1'b1; data_out = 4'h3;
    drive(0, 1, 4'h4);
    chk("lit_mrst_stray0", 32'(stray_err), 32'h1);
    drive(0, 0, 4'h0);
    chk("lit_mrst_stray1", 32'(stray_err), 32'h1);

    // Arm with coincident word in IDLE (ignored), then re-arm mid-run
    drive(1, 1, 4'hC);
    drive(0, 1, 4'h1);
    chk("lit_r6_nostray", 32'(stray_err), 32'h0);
    chk("lit_r6_cnt0",    32'(word_cnt),  32'h0);
    drive(0, 1, 4'h2);
    drive(0, 1, 4'h3);
    drive(1, 1, 4'hF);
    drive(0, 1, 4'h2);
    chk("lit_r6_rearm_cnt", 32'(word_cnt), 32'h1);
    drive(0, 1, 4'h5);
    drive(0, 1, 4'h6);
    drive(0, 0, 4'h0);
    chk("lit_r6_done",  32'(done),      32'h1);
    chk("lit_r6_arr",   32'(data_arr),  32'h652F);
    chk("lit_r6_cnt",   32'(word_cnt),  32'h4);
    chk("lit_r6_order", 32'(order_err), 32'h1);
    repeat (2) drive(0, 0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_result_collector.md
Name: sort_result_collector

Overview:
- Receive-side counterpart of the sorter's result stream: consumes the serial out_vld/data_out words the sorter emits after start_sort.
- Deserialises DATA_N words back into an array and checks they arrive in non-decreasing order.
- Flags timeout and stray words; used by the system controller and the test harness to obtain the sorted vector.

Parameters:
- DATA_N, 4, number of words per sort run (>=2)
- DATA_W, 4, bits per word
- TIMEOUT_CYC, 64, max cycles allowed between arm and first word, and between consecutive words (>=1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- arm  input  1  one-cycle pulse issued alongside start_sort; opens a collection run
- out_vld  input  1  sorter word-valid strobe
- data_out  input  DATA_W  sorter result word, sampled when out_vld=1
- data_arr  output  DATA_N x DATA_W  collected words, index 0 = first received
- done  output  1  one-cycle pulse: run completed with DATA_N words
- busy  output  1  high while a run is open
- order_err  output  1  valid with done: some word was smaller than its predecessor
- timeout_err  output  1  one-cycle pulse: run aborted by timeout
- stray_err  output  1  one-cycle pulse: out_vld seen while no run is open
- word_cnt  output  $clog2(DATA_N+1)  words captured in the current/last run

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clock edge): state IDLE; data_arr all 0, word_cnt 0, busy/done/order_err/timeout_err/stray_err 0, timer 0. Applies mid-run: the partial run is discarded, no done or error pulse.
- States: IDLE, COLLECT. busy = (state==COLLECT), registered.
- IDLE: arm=1 -> COLLECT; word_cnt, timer and the internal order flag clear; data_arr holds its old contents until overwritten. out_vld=1 with arm=0 -> stray_err pulse next cycle, word discarded. out_vld=1 in the same cycle as arm -> word ignored, no stray_err.
- COLLECT: out_vld=1 -> data_arr[word_cnt] <= data_out, word_cnt increments, timer clears. From the second word on, data_out is compared unsigned with the previous word; if data_out < previous, the order flag sets (sticky for the run). Equal words are legal.
- Completion: the cycle that captures word DATA_N-1 moves the FSM to IDLE. Next cycle: done=1 for one cycle, order_err = the final order flag, busy=0, word_cnt=DATA_N. order_err holds until the next arm.
- Timeout: in COLLECT with out_vld=0, the timer increments each cycle. When it reaches TIMEOUT_CYC-1 with no word, the FSM goes to IDLE and timeout_err pulses the next cycle. word_cnt keeps the partial count; done does not pulse.
- Re-arm while busy: arm=1 in COLLECT restarts the run (count, timer and flag clear). If out_vld=1 in the same cycle, that word becomes word 0 of the new run.
- Latency: done occurs 1 cycle after the last word is sampled. Back-to-back runs: arm is accepted in the same cycle done is high.
- Outputs: all registered; no combinational path from input to output.

Decomposition:
- Shared package sort_pkg holds:
  - the state enum (IDLE, COLLECT);
  - localparam helper CNT_W = $clog2(DATA_N+1);
  - the default DATA_N/DATA_W values shared with the sorter and its interface.
- One natural sub-module, sort_order_chk: registers the previous word, does the compare and keeps the sticky flag, with clear and enable inputs.

Test Plan:
- Arm, then 4 words 1,3,3,9 on consecutive cycles -> done pulse 1 cycle after the 4th word; data_arr={1,3,3,9}; order_err=0; word_cnt=4.
- Arm, then words 5,2,7,8 with 2-cycle gaps -> done; data_arr={5,2,7,8}; order_err=1.
- Arm, 2 words, then idle 64 cycles -> timeout_err pulses once; busy=0; word_cnt=2; no done.
- out_vld with word 0xA in IDLE and no arm -> stray_err pulse; data_arr unchanged.
- Arm, 2 words, rst_n=0 for one cycle, then 2 words -> all outputs 0 after reset; no done; stray_err pulses on each post-reset word.
- Arm, 3 words, re-arm in the same cycle as word 0xF, then 3 more words -> done; data_arr[0]=0xF; word_cnt=4.
